// File: rtl/run_ctrl.sv
// Run controller: sequences core reset/enable, enforces a cycle budget, and handles stop/step/resume.
// Define RUN_CTRL_BP_EN to build the PC breakpoint comparators and the post-resume breakpoint mask.
module run_ctrl #(
    parameter int PC_W       = 32,
    parameter int CNT_W      = 32,
    parameter int RST_CYCLES = 2,
    parameter int NUM_BP     = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   resume,
    input  logic                   step,
    input  logic [CNT_W-1:0]       budget,
    input  logic [PC_W-1:0]        pc,
    input  logic [NUM_BP*PC_W-1:0] bp_addr,
    input  logic [NUM_BP-1:0]      bp_valid,
    output logic                   core_rst_n,
    output logic                   core_en,
    output logic [CNT_W-1:0]       cycle_cnt,
    output logic                   done,
    output logic [1:0]             halt_cause,
    output logic [2:0]             state_o
);

    localparam int RST_W = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CRST = 3'd1,
        RUN  = 3'd2,
        STEP = 3'd3,
        HALT = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [RST_W-1:0] rst_cnt;
    logic [CNT_W-1:0] budget_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [1:0]       cause_nxt;
    logic             bp_hit;
    logic             budget_hit;
    logic             start_go;

    assign cnt_inc    = (&cycle_cnt) ? cycle_cnt : cycle_cnt + CNT_W'(1);
    assign budget_hit = (budget_q != '0) && (cnt_inc == budget_q);
    assign start_go   = (state_nxt == CRST) && (state != CRST);

`ifdef RUN_CTRL_BP_EN
    logic resume_mask;
    logic bp_match;

    always_comb begin
        bp_match = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (bp_valid[i] && (pc == bp_addr[i*PC_W +: PC_W])) begin
                bp_match = 1'b1;
            end
        end
    end

    // Masking the first cycle after resume lets the core execute the breakpoint instruction.
    assign bp_hit = bp_match && !resume_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resume_mask <= 1'b0;
        end else begin
            resume_mask <= (state == HALT) && (state_nxt == RUN);
        end
    end
`else
    logic unused_bp;
    assign unused_bp = ^{pc, bp_addr, bp_valid};
    assign bp_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cause_nxt = halt_cause;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CRST;
                    cause_nxt = 2'd0;
                end
            end
            CRST: begin
                if (rst_cnt == '0) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (start) begin
                    state_nxt = CRST;
                    cause_nxt = 2'd0;
                end else if (stop) begin
                    state_nxt = HALT;
                    cause_nxt = 2'd2;
                end else if (bp_hit) begin
                    state_nxt = HALT;
                    cause_nxt = 2'd3;
                end else if (budget_hit) begin
                    state_nxt = HALT;
                    cause_nxt = 2'd1;
                end
            end
            STEP: begin
                state_nxt = HALT;
                cause_nxt = budget_hit ? 2'd1 : 2'd0;
            end
            HALT: begin
                // An exhausted budget cannot be resumed; only a new start or a step leaves HALT.
                if (start) begin
                    state_nxt = CRST;
                    cause_nxt = 2'd0;
                end else if (resume && (halt_cause != 2'd1)) begin
                    state_nxt = RUN;
                end else if (step) begin
                    state_nxt = STEP;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        core_en    = ((state == RUN) && !stop && !bp_hit) || (state == STEP);
        core_rst_n = (state != IDLE) && (state != CRST);
        done       = (state == HALT);
        state_o    = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            budget_q   <= '0;
            cycle_cnt  <= '0;
            rst_cnt    <= '0;
            halt_cause <= 2'd0;
        end else begin
            halt_cause <= cause_nxt;
            if (start_go) begin
                budget_q  <= budget;
                cycle_cnt <= '0;
                rst_cnt   <= RST_W'(RST_CYCLES - 1);
            end else begin
                if ((state == CRST) && (rst_cnt != '0)) begin
                    rst_cnt <= rst_cnt - RST_W'(1);
                end
                if (core_en) begin
                    cycle_cnt <= cnt_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// Directed testbench for run_ctrl: budget runs, breakpoints, stop/step, restart priority and async reset.
module tb_run_ctrl;

    localparam int PC_W  = 32;
    localparam int CNT_W = 32;

    logic              clk;
    logic              rst_n;
    logic              start, stop, resume, step;
    logic [CNT_W-1:0]  budget;
    logic [PC_W-1:0]   pc;
    logic [2*PC_W-1:0] bp_addr;
    logic [1:0]        bp_valid;
    logic              core_rst_n, core_en, done;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [1:0]        halt_cause;
    logic [2:0]        state_o;

    int total;
    int bad;

    run_ctrl #(
        .PC_W(PC_W), .CNT_W(CNT_W), .RST_CYCLES(2), .NUM_BP(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .resume(resume), .step(step),
        .budget(budget), .pc(pc), .bp_addr(bp_addr), .bp_valid(bp_valid),
        .core_rst_n(core_rst_n), .core_en(core_en), .cycle_cnt(cycle_cnt), .done(done),
        .halt_cause(halt_cause), .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Minimal core model: PC restarts at 0 under core reset and advances 4 per enabled cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (!core_rst_n) begin
            pc <= '0;
        end else if (core_en) begin
            pc <= pc + 32'd4;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic sp, input logic rs, input logic stp);
        start  = st;
        stop   = sp;
        resume = rs;
        step   = stp;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_state"}, 32'(state_o), 32'd0);
        checkOutput({tag, "_rstn"}, 32'(core_rst_n), 32'd0);
        checkOutput({tag, "_en"}, 32'(core_en), 32'd0);
        checkOutput({tag, "_cnt"}, cycle_cnt, 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_cause"}, 32'(halt_cause), 32'd0);
    endtask

    // Pulse start and walk through the two core-reset cycles into RUN.
    task automatic startRun(input logic [31:0] b, input string tag);
        budget = b;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput({tag, "_crst_state"}, 32'(state_o), 32'd1);
        checkOutput({tag, "_crst_rstn"}, 32'(core_rst_n), 32'd0);
        checkOutput({tag, "_crst_en"}, 32'(core_en), 32'd0);
        checkOutput({tag, "_crst_cnt"}, cycle_cnt, 32'd0);
        tick();
        checkOutput({tag, "_crst2_rstn"}, 32'(core_rst_n), 32'd0);
        tick();
        checkOutput({tag, "_run_state"}, 32'(state_o), 32'd2);
        checkOutput({tag, "_run_rstn"}, 32'(core_rst_n), 32'd1);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        budget   = '0;
        bp_addr  = '0;
        bp_valid = '0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        #12;
        checkReset("reset");
        rst_n = 1'b1;
        tick();
        checkOutput("idle_hold", 32'(state_o), 32'd0);

        // Budget of 10: exactly 10 enabled cycles, then HALT with cause 1.
        startRun(32'd10, "s1");
        for (int i = 0; i < 10; i++) begin
            checkOutput("s1_en", 32'(core_en), 32'd1);
            tick();
        end
        checkOutput("s1_en_off", 32'(core_en), 32'd0);
        checkOutput("s1_done", 32'(done), 32'd1);
        checkOutput("s1_cnt", cycle_cnt, 32'd10);
        checkOutput("s1_cause", 32'(halt_cause), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("s1_resume_ign", 32'(state_o), 32'd4);
        checkOutput("s1_resume_en", 32'(core_en), 32'd0);
        checkOutput("s1_resume_cnt", cycle_cnt, 32'd10);

        // Breakpoint at 0x10 with PC advancing by 4 from 0.
        bp_addr  = {32'h0000_0000, 32'h0000_0010};
        bp_valid = 2'b01;
        startRun(32'd0, "s2");
        for (int i = 0; i < 4; i++) begin
            checkOutput("s2_en", 32'(core_en), 32'd1);
            tick();
        end
        checkOutput("s2_cnt4", cycle_cnt, 32'd4);
`ifdef RUN_CTRL_BP_EN
        checkOutput("s2_bp_en", 32'(core_en), 32'd0);
        tick();
        checkOutput("s2_bp_done", 32'(done), 32'd1);
        checkOutput("s2_bp_cause", 32'(halt_cause), 32'd3);
        checkOutput("s2_bp_cnt", cycle_cnt, 32'd4);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("s2_res_state", 32'(state_o), 32'd2);
        checkOutput("s2_res_en", 32'(core_en), 32'd1);
        tick();
        checkOutput("s2_res_cnt", cycle_cnt, 32'd5);
        checkOutput("s2_res_en2", 32'(core_en), 32'd1);
`else
        checkOutput("s2_nobp_en", 32'(core_en), 32'd1);
        tick();
        checkOutput("s2_nobp_state", 32'(state_o), 32'd2);
        checkOutput("s2_nobp_cnt", cycle_cnt, 32'd5);
        checkOutput("s2_nobp_done", 32'(done), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("s2_stop_en", 32'(core_en), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("s2_stop_done", 32'(done), 32'd1);
        checkOutput("s2_stop_cause", 32'(halt_cause), 32'd2);
`endif

        // Stop after 5 enabled cycles, then three single steps.
        bp_valid = 2'b00;
        startRun(32'd0, "s3");
        for (int i = 0; i < 5; i++) begin
            checkOutput("s3_en", 32'(core_en), 32'd1);
            tick();
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("s3_stop_en", 32'(core_en), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("s3_done", 32'(done), 32'd1);
        checkOutput("s3_cause", 32'(halt_cause), 32'd2);
        checkOutput("s3_cnt", cycle_cnt, 32'd5);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
            tick();
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("s3_step_state", 32'(state_o), 32'd3);
            checkOutput("s3_step_en", 32'(core_en), 32'd1);
            tick();
            checkOutput("s3_step_halt", 32'(done), 32'd1);
            checkOutput("s3_step_en_off", 32'(core_en), 32'd0);
        end
        checkOutput("s3_step_cnt", cycle_cnt, 32'd8);
        checkOutput("s3_step_cause", 32'(halt_cause), 32'd0);

        // Budget 3: stop at 2, a step reaches the budget so cause becomes 1 and resume is refused.
        startRun(32'd3, "s4");
        tick();
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("s4_stop_cause", 32'(halt_cause), 32'd2);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("s4_step_cnt", cycle_cnt, 32'd3);
        checkOutput("s4_step_cause", 32'(halt_cause), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("s4_resume_ign", 32'(state_o), 32'd4);

        // start + stop + resume together in RUN: start wins.
        startRun(32'd0, "s5");
        tick();
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("s5_en", 32'(core_en), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("s5_state", 32'(state_o), 32'd1);
        checkOutput("s5_cnt", cycle_cnt, 32'd0);
        checkOutput("s5_rstn", 32'(core_rst_n), 32'd0);
        tick();
        tick();
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        checkOutput("s6_cnt7", cycle_cnt, 32'd7);

        // Asynchronous reset in the middle of a run.
        #2;
        rst_n = 1'b0;
        #1;
        checkReset("s6_async");
        #2;
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        checkOutput("s6_idle_state", 32'(state_o), 32'd0);
        checkOutput("s6_idle_rstn", 32'(core_rst_n), 32'd0);
        checkOutput("s6_idle_en", 32'(core_en), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Parametrised run controller for the processor cores (single-cycle and pipelined). It generates the core's synchronous reset and clock-enable, enforces a cycle budget, and supports stop, single-step, resume and optional PC breakpoints. It sits between the top-level clock/reset and the core instance, so fixed-length runs, debug halts and cycle counts are handled in RTL rather than by bench timing.

## Interface
Parameters:
- PC_W, 32, width of the program counter compared against breakpoints
- CNT_W, 32, width of the cycle counter and budget
- RST_CYCLES, 2, number of cycles `core_rst_n` is held low after `start` (minimum 1)
- NUM_BP, 2, number of breakpoint comparators (minimum 1)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: reset the core and begin a run
- stop  in  1  pulse: halt a running core
- resume  in  1  pulse: continue from HALT without a core reset
- step  in  1  pulse: execute exactly one core cycle from HALT
- budget  in  CNT_W  cycle limit, latched on `start`; 0 = unlimited
- pc  in  PC_W  current core PC
- bp_addr  in  NUM_BP*PC_W  breakpoint addresses; slot i is bits [i*PC_W +: PC_W]
- bp_valid  in  NUM_BP  per-slot breakpoint enable
- core_rst_n  out  1  active-low reset to the core
- core_en  out  1  core clock-enable
- cycle_cnt  out  CNT_W  number of enabled core cycles since the last `start`
- done  out  1  high while in HALT
- halt_cause  out  2  0 none/step, 1 budget, 2 stop, 3 breakpoint
- state_o  out  3  current FSM state, for debug

## Operation
- States: IDLE=0, CRST=1, RUN=2, STEP=3, HALT=4.
- Reset values: IDLE, core_rst_n=0, core_en=0, cycle_cnt=0, done=0, halt_cause=0, latched budget=0, reset counter=0.
- Input priority within a cycle: start > stop > resume > step. Inputs that are not valid in the current state are ignored.
- IDLE/HALT/RUN + start: latch `budget`, clear cycle_cnt and halt_cause, load the reset counter, go to CRST.
- CRST: core_rst_n=0 and core_en=0 for RST_CYCLES cycles, then go to RUN.
- RUN: core_rst_n=1.
  - core_en is combinational: `(state==RUN) && !stop && !bp_hit`.
  - Each cycle with core_en=1 increments cycle_cnt, saturating at all-ones.
  - Exit to HALT with cause 2 on `stop`.
  - Exit to HALT with cause 3 on bp_hit. The breakpoint instruction is not executed.
  - Exit to HALT with cause 1 when an enabled cycle makes cycle_cnt equal to a nonzero budget.
  - If two causes fire together: stop beats breakpoint, breakpoint beats budget.
- bp_hit: any i with bp_valid[i] && pc==bp_addr[i]. It is masked in the first RUN cycle after a resume, so a resume from a breakpoint halt makes progress.
- HALT: done=1, core_en=0.
  - resume goes to RUN. It is ignored when halt_cause==1, because the budget is exhausted.
  - step goes to STEP.
- STEP: core_en=1 for exactly one cycle, breakpoints ignored, cycle_cnt increments. Then return to HALT with halt_cause=0. If the step exhausts a nonzero budget, halt_cause=1 instead.

## Timing
- start sampled at edge t: CRST from t. core_rst_n rises and core_en first asserts at edge t+RST_CYCLES.
- With budget B>0 and no other events, core_en is high for exactly B consecutive cycles. done rises on the edge that follows the B-th enabled cycle.
- stop and breakpoints drop core_en in the same cycle, with zero latency. done rises at the next edge.
- rst_n low at any time forces the reset values immediately. The core is held in reset until a new start.

## Configuration
- RUN_CTRL_BP_EN defined: the NUM_BP comparators and the resume mask are built.
- RUN_CTRL_BP_EN undefined: bp_hit is tied to 0, bp_addr and bp_valid are ignored, and halt_cause never takes the value 3.

## Test plan
- RST_CYCLES=2, start with budget=10: core_rst_n low for 2 cycles, then core_en high for exactly 10 cycles, then HALT with cycle_cnt=10, halt_cause=1, done=1. A following resume is ignored.
- budget=0, bp_addr[0]=0x0000_0010, bp_valid=01, PC advancing by 4 per cycle from 0: core_en drops in the cycle pc=0x10, with halt_cause=3 and cycle_cnt=4. Resume executes pc=0x10 and continues.
- budget=0, stop pulsed after 5 enabled cycles: core_en is low in the stop cycle, and the block halts with cycle_cnt=5, halt_cause=2. Three step pulses give cycle_cnt=8, halt_cause=0, and core_en high exactly 3 single cycles.
- start, stop and resume asserted together in RUN: a restart occurs (CRST entered, cycle_cnt=0).
- rst_n pulsed low mid-RUN (cycle_cnt=7): all outputs return to reset values asynchronously and the block stays in IDLE until start.
- Build without RUN_CTRL_BP_EN, with the breakpoint from the second scenario enabled: the run continues past pc=0x10 and halts only on stop or budget.
